// File: rtl/onn_phase_ctrl.sv
// Trigger sequencer for the ONN phase-register bank: re -> drop -> periodic state checks,
// ending in convergence (a run of quiet checks) or timeout. All outputs are registered.
module onn_phase_ctrl #(
  parameter int N_NEURONS     = 15,
  parameter int CHECK_PERIOD  = 16,
  parameter int SAMPLE_DLY    = 2,
  parameter int STABLE_CHECKS = 2,
  parameter int MAX_ITER      = 255,
  parameter int ITER_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N_NEURONS-1:0] state_changed,
  output logic                 re,
  output logic                 drop,
  output logic                 state_cheak,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic                 timeout,
  output logic [ITER_W-1:0]    iter_count
);

  typedef enum logic [2:0] {IDLE, RE_HI, GAP, DROP_HI, SETTLE, CHK_HI, SAMPLE, DONE} state_t;

  localparam int CNT_MAX = (CHECK_PERIOD > SAMPLE_DLY) ? CHECK_PERIOD : SAMPLE_DLY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STB_W   = $clog2(STABLE_CHECKS + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(CHECK_PERIOD - 1);
  // CHK_HI is the first of the SAMPLE_DLY cycles, so SAMPLE itself lasts SAMPLE_DLY-1
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_DLY - 2);
  localparam logic [STB_W-1:0]  STB_DONE    = STB_W'(STABLE_CHECKS);
  localparam logic [ITER_W-1:0] ITER_DONE   = ITER_W'(MAX_ITER);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [STB_W-1:0]  stable_cnt, stable_nxt, stable_inc;
  logic [ITER_W-1:0] iter_nxt, iter_inc;
  logic              done_nxt, conv_nxt, tmo_nxt;

  always_comb begin
    state_nxt  = state;
    stable_nxt = stable_cnt;
    iter_nxt   = iter_count;
    done_nxt   = done;
    conv_nxt   = converged;
    tmo_nxt    = timeout;
    iter_inc   = (iter_count == '1) ? iter_count : iter_count + 1'b1;
    stable_inc = (|state_changed) ? '0 : stable_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = RE_HI;
          stable_nxt = '0;
          iter_nxt   = '0;
          done_nxt   = 1'b0;
          conv_nxt   = 1'b0;
          tmo_nxt    = 1'b0;
        end
      end
      RE_HI:   state_nxt = GAP;
      GAP:     state_nxt = DROP_HI;
      DROP_HI: state_nxt = SETTLE;
      SETTLE:  if (cnt == SETTLE_LAST) state_nxt = CHK_HI;
      CHK_HI:  state_nxt = SAMPLE;
      SAMPLE: begin
        if (cnt == SAMPLE_LAST) begin
          iter_nxt   = iter_inc;
          stable_nxt = stable_inc;
          // convergence wins when it coincides with the iteration limit
          if (stable_inc == STB_DONE) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            conv_nxt  = 1'b1;
          end else if (iter_inc == ITER_DONE) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            tmo_nxt   = 1'b1;
          end else begin
            state_nxt = SETTLE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (abort && (state != IDLE)) begin
      state_nxt  = IDLE;
      stable_nxt = stable_cnt;
      iter_nxt   = iter_count;
      done_nxt   = 1'b0;
      conv_nxt   = 1'b0;
      tmo_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      stable_cnt  <= '0;
      iter_count  <= '0;
      re          <= 1'b0;
      drop        <= 1'b0;
      state_cheak <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state      <= state_nxt;
      stable_cnt <= stable_nxt;
      iter_count <= iter_nxt;
      done       <= done_nxt;
      converged  <= conv_nxt;
      timeout    <= tmo_nxt;
      if ((state_nxt == state) && ((state == SETTLE) || (state == SAMPLE)))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      // outputs decoded from the next state so each trigger is a clean registered level
      re          <= (state_nxt == RE_HI);
      drop        <= (state_nxt == DROP_HI);
      state_cheak <= (state_nxt == CHK_HI);
      busy        <= (state_nxt != IDLE) && (state_nxt != DONE);
    end
  end

endmodule

// File: doc/onn_phase_ctrl.md
Name: onn_phase_ctrl

Overview:
Sequencer driving the trigger side of the ONN phase-register array (3x5 = 15 neurons). It issues the reset, drop and state-check trigger levels shared by all phase registers. It gathers their per-neuron state_changed flags and declares the network converged after a run of consecutive checks with no phase change, or declares timeout. It sits between the top-level run control and the phase-register bank.

Parameters:
N_NEURONS, 15, number of phase registers / width of the state_changed vector
CHECK_PERIOD, 16, oscillator settle cycles between successive checks (>=1)
SAMPLE_DLY, 2, cycles after check assertion before the flags are evaluated (>=2)
STABLE_CHECKS, 2, consecutive no-change checks required for convergence (>=1)
MAX_ITER, 255, check iterations before timeout (>=1, < 2**ITER_W)
ITER_W, 8, width of iter_count

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
state_changed  in  N_NEURONS  per-neuron change flags from the phase registers
re  out  1  reset trigger level to phase registers
drop  out  1  drop trigger level (load initial phase)
state_cheak  out  1  phase-check trigger level
busy  out  1  high while a run is in progress
done  out  1  run finished; held until next accepted start
converged  out  1  valid with done: network stable
timeout  out  1  valid with done: MAX_ITER reached without convergence
iter_count  out  ITER_W  checks evaluated in the current or last run

Behaviour:
- Reset (rst_n=0, async): state=IDLE; every output 0; internal counters 0.
- All outputs are registered. Each trigger is high for exactly 1 cycle and is followed by at least 1 low cycle, because the receivers detect rising edges.
- FSM states: IDLE, RE_HI, GAP, DROP_HI, SETTLE, CHK_HI, SAMPLE, DONE.
- IDLE: with start=1 at a clock edge -> RE_HI. On that same edge, clear done/converged/timeout/iter_count/stable count and set busy=1.
- RE_HI: re=1 for 1 cycle -> GAP.
- GAP: all triggers 0 for 1 cycle -> DROP_HI.
- DROP_HI: drop=1 for 1 cycle -> SETTLE.
- SETTLE: triggers 0 for CHECK_PERIOD cycles -> CHK_HI.
- CHK_HI: state_cheak=1 for 1 cycle -> SAMPLE.
- SAMPLE: SAMPLE_DLY cycles counted from CHK_HI entry; evaluation happens on the last cycle.
  - Evaluation: iter_count+1 (saturating). If the OR of state_changed is 1, clear the stable count; otherwise increment it.
  - stable count reaches STABLE_CHECKS -> DONE with converged=1.
  - otherwise, iter_count new value == MAX_ITER -> DONE with timeout=1.
  - otherwise -> SETTLE.
  - Convergence and MAX_ITER on the same evaluation: converged=1, timeout=0.
- DONE: busy=0, done=1, result flags held. -> IDLE on the next cycle. done/converged/timeout/iter_count stay held in IDLE until the next accepted start.
- start while busy: ignored. start held high: exactly one run per IDLE entry.
- abort=1 in any non-IDLE state: next state IDLE; triggers 0; busy=0; done=0; converged=0; timeout=0; iter_count keeps its value. abort has priority over every other transition. abort in IDLE has no effect.
- rst_n asserted mid-run: immediate return to the reset values above.
- state_changed is sampled only on the evaluation cycle; it is don't-care elsewhere.
- Latency: start edge to first state_cheak rise = 3 + CHECK_PERIOD + 1 cycles (default 20). One check iteration = CHECK_PERIOD + 1 + SAMPLE_DLY - 1 cycles (default 18).

Test Plan:
- Reset/idle: rst_n low then high, no start -> re=drop=state_cheak=busy=done=0 and iter_count=0 for 50 cycles.
- Trigger sequence, default params: start pulse at cycle 0 -> re high at cycle 1 only, drop at cycle 3 only, first state_cheak at cycle 20. Each trigger is preceded and followed by a low cycle.
- Convergence: state_changed=15'h0004 at evaluation 1, then 0 at evaluations 2 and 3 -> done=1, converged=1, timeout=0, iter_count=3.
- Timeout: MAX_ITER=4, state_changed held at 15'h7FFF -> done after evaluation 4, timeout=1, converged=0, iter_count=4. Coincidence variant, STABLE_CHECKS=1, MAX_ITER=1, flags 0 -> converged=1, timeout=0.
- Abort/reset mid-run: abort during SETTLE of iteration 2 -> IDLE next cycle, busy=0, done=0, iter_count=1. Repeat with rst_n low during CHK_HI -> state_cheak drops at once and all outputs are 0.
- Start handling: start held high for 100 cycles with a converging stimulus -> second run begins only after DONE; start pulses issued during busy are ignored (no extra re pulse).
